// File: rtl/decoder_pkg.sv
// Shared state encodings and elaboration helpers for the registered N-to-2^N decoder.
package decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_SCAN   = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << result) < value) result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/scan_counter.sv
// Dwell counter and line index for the scan driver; also loads the index directly in decode mode.
module scan_counter
  import decoder_pkg::*;
#(
  parameter int SEL_W = 3,
  parameter int DWELL = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [SEL_W-1:0] load_val,
  input  logic             advance,
  output logic [SEL_W-1:0] idx,
  output logic [SEL_W-1:0] idx_next,
  output logic             wrap_pulse
);

  localparam int CNT_W = (clog2(DWELL) < 1) ? 1 : clog2(DWELL);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [SEL_W-1:0] idx_reg;
  logic             wrap_reg, wrap_next;

  always_comb begin
    cnt_next  = cnt_reg;
    idx_next  = idx_reg;
    wrap_next = 1'b0;
    if (load) begin
      cnt_next = '0;
      idx_next = load_val;
    end else if (advance) begin
      if (cnt_reg == CNT_LAST) begin
        cnt_next  = '0;
        idx_next  = idx_reg + 1'b1;
        // Line count is a power of two, so the natural rollover is the wrap.
        wrap_next = &idx_reg;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end else if (clr) begin
      cnt_next = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg  <= '0;
      idx_reg  <= '0;
      wrap_reg <= 1'b0;
    end else begin
      cnt_reg  <= cnt_next;
      idx_reg  <= idx_next;
      wrap_reg <= wrap_next;
    end
  end

  assign idx        = idx_reg;
  assign wrap_pulse = wrap_reg;

endmodule

// File: rtl/decoder_nx2n_seq.sv
// Registered one-hot decoder with enable and auto-scan; FSM picks decode, scan-load or scan-advance.
module decoder_nx2n_seq
  import decoder_pkg::*;
#(
  parameter int SEL_W = 3,
  parameter int DWELL = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  output logic [(1<<SEL_W)-1:0]   y,
  output logic [SEL_W-1:0]        idx,
  output logic                    valid,
  output logic                    wrap
);

  localparam int NOUT = 1 << SEL_W;
  localparam logic [NOUT-1:0] ONE = NOUT'(1);

  state_t           state_reg;
  logic [NOUT-1:0]  y_reg;
  logic             valid_reg;
  logic             clr, load, advance;
  logic [SEL_W-1:0] idx_next;

  always_comb begin
    clr     = !en;
    load    = en && (!mode || (state_reg != ST_SCAN));
    advance = en && mode && (state_reg == ST_SCAN);
  end

  scan_counter #(
    .SEL_W(SEL_W),
    .DWELL(DWELL)
  ) u_scan_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .load      (load),
    .load_val  (sel),
    .advance   (advance),
    .idx       (idx),
    .idx_next  (idx_next),
    .wrap_pulse(wrap)
  );

  // y is built from the counter's next index so it lands on the same edge as idx.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      y_reg     <= '0;
      valid_reg <= 1'b0;
    end else if (!en) begin
      state_reg <= ST_IDLE;
      y_reg     <= '0;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= mode ? ST_SCAN : ST_DECODE;
      y_reg     <= ONE << idx_next;
      valid_reg <= 1'b1;
    end
  end

  assign y     = y_reg;
  assign valid = valid_reg;

endmodule

// File: tb/tb_decoder_nx2n_seq.sv
// Directed and randomized checks of two decoder builds against an elapsed-time scan model.
module tb_decoder_nx2n_seq;

  logic       clk = 1'b0;
  logic       rst_a, en_a, mode_a;
  logic [2:0] sel_a;
  logic [7:0] y_a;
  logic [2:0] idx_a;
  logic       valid_a, wrap_a;
  logic       rst_b, en_b, mode_b;
  logic [0:0] sel_b;
  logic [1:0] y_b;
  logic [0:0] idx_b;
  logic       valid_b, wrap_b;

  int checks = 0;
  int errors = 0;

  int nout [2] = '{8, 2};
  int dwell[2] = '{2, 1};
  int m_idx[2], m_act[2], m_scan[2], m_start[2], m_el[2], m_wrap[2];

  always #5 clk = ~clk;

  decoder_nx2n_seq #(.SEL_W(3), .DWELL(2)) dut_a (
    .clk(clk), .rst_n(rst_a), .en(en_a), .mode(mode_a), .sel(sel_a),
    .y(y_a), .idx(idx_a), .valid(valid_a), .wrap(wrap_a)
  );

  decoder_nx2n_seq #(.SEL_W(1), .DWELL(1)) dut_b (
    .clk(clk), .rst_n(rst_b), .en(en_b), .mode(mode_b), .sel(sel_b),
    .y(y_b), .idx(idx_b), .valid(valid_b), .wrap(wrap_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset(input int k);
    m_idx[k] = 0; m_act[k] = 0; m_scan[k] = 0; m_wrap[k] = 0; m_el[k] = 0;
  endtask

  // Scan position is derived from time spent in scan, not from a counter.
  task automatic model_step(input int k, input bit e, input bit m, input int s);
    if (!e) begin
      m_act[k] = 0; m_scan[k] = 0; m_wrap[k] = 0;
    end else if (!m) begin
      m_act[k] = 1; m_scan[k] = 0; m_idx[k] = s; m_wrap[k] = 0;
    end else if (m_scan[k] == 0) begin
      m_act[k] = 1; m_scan[k] = 1; m_start[k] = s; m_el[k] = 0; m_idx[k] = s; m_wrap[k] = 0;
    end else begin
      m_el[k]++;
      m_idx[k]  = (m_start[k] + m_el[k] / dwell[k]) % nout[k];
      m_wrap[k] = ((m_el[k] % dwell[k]) == 0 && m_idx[k] == 0) ? 1 : 0;
    end
  endtask

  task automatic check_all();
    check("a.y",     32'(y_a),     m_act[0] ? (32'd1 << m_idx[0]) : 32'd0);
    check("a.idx",   32'(idx_a),   32'(m_idx[0]));
    check("a.valid", 32'(valid_a), 32'(m_act[0]));
    check("a.wrap",  32'(wrap_a),  32'(m_wrap[0]));
    check("b.y",     32'(y_b),     m_act[1] ? (32'd1 << m_idx[1]) : 32'd0);
    check("b.idx",   32'(idx_b),   32'(m_idx[1]));
    check("b.valid", 32'(valid_b), 32'(m_act[1]));
    check("b.wrap",  32'(wrap_b),  32'(m_wrap[1]));
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst_a) model_step(0, en_a, mode_a, int'(sel_a)); else model_reset(0);
    if (rst_b) model_step(1, en_b, mode_b, int'(sel_b)); else model_reset(1);
    #1;
    check_all();
    $display("t=%0t a: en=%0b mode=%0b sel=%0d y=%02h idx=%0d v=%0b w=%0b | b: en=%0b mode=%0b y=%0b idx=%0d w=%0b",
             $time, en_a, mode_a, sel_a, y_a, idx_a, valid_a, wrap_a, en_b, mode_b, y_b, idx_b, wrap_b);
  endtask

  logic [7:0] seq_a [7];
  logic [1:0] seq_b [5];
  logic       wrp_a [7];
  logic       wrp_b [5];

  initial begin
    seq_a = '{8'h40, 8'h40, 8'h80, 8'h80, 8'h01, 8'h01, 8'h02};
    wrp_a = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    seq_b = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
    wrp_b = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    rst_a = 1'b0; en_a = 1'b0; mode_a = 1'b0; sel_a = '0;
    rst_b = 1'b0; en_b = 1'b0; mode_b = 1'b0; sel_b = '0;
    model_reset(0); model_reset(1);
    #2;
    check_all();
    @(negedge clk);
    rst_a = 1'b1; rst_b = 1'b1;

    // Disabled: everything stays low.
    for (int i = 0; i < 5; i++) cycle();

    // Decode mode tracks sel with one cycle of latency.
    en_a = 1'b1; sel_a = 3'd5;
    cycle();
    check("dec5.y", 32'(y_a), 32'h20);
    check("dec5.idx", 32'(idx_a), 32'd5);
    sel_a = 3'd2;
    cycle();
    check("dec2.y", 32'(y_a), 32'h04);
    check("dec2.valid", 32'(valid_a), 32'd1);

    // Scan from line 6 through the wrap.
    mode_a = 1'b1; sel_a = 3'd6;
    for (int i = 0; i < 7; i++) begin
      cycle();
      check("scan.y", 32'(y_a), 32'(seq_a[i]));
      check("scan.wrap", 32'(wrap_a), 32'(wrp_a[i]));
      sel_a = 3'(i);
    end

    // Drop to decode mid-scan, then re-enter scan from the new sel.
    mode_a = 1'b0; sel_a = 3'd3;
    cycle();
    check("mid.dec.y", 32'(y_a), 32'h08);
    mode_a = 1'b1;
    cycle();
    check("reload.y", 32'(y_a), 32'h08);
    check("reload.wrap", 32'(wrap_a), 32'd0);
    sel_a = 3'd0;
    for (int i = 0; i < 3; i++) cycle();
    check("reload.adv.y", 32'(y_a), 32'h10);

    // Asynchronous reset between edges.
    #2 rst_a = 1'b0;
    #1;
    model_reset(0);
    check("arst.y", 32'(y_a), 32'h00);
    check("arst.idx", 32'(idx_a), 32'd0);
    check("arst.valid", 32'(valid_a), 32'd0);
    check("arst.wrap", 32'(wrap_a), 32'd0);
    #1 rst_a = 1'b1;
    cycle();
    check("arst.reload.y", 32'(y_a), 32'h01);

    // Single-bit, DWELL = 1 build: toggles every cycle, wraps on 10 -> 01.
    en_b = 1'b1; mode_b = 1'b1; sel_b = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("b.scan.y", 32'(y_b), 32'(seq_b[i]));
      check("b.scan.wrap", 32'(wrap_b), 32'(wrp_b[i]));
      sel_b = 1'b1;
    end

    // Randomized traffic on both builds with occasional input changes.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        en_a   = ($urandom_range(0, 7) != 0);
        mode_a = ($urandom_range(0, 2) != 0);
        sel_a  = 3'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 5) == 0) begin
        en_b   = ($urandom_range(0, 7) != 0);
        mode_b = ($urandom_range(0, 2) != 0);
        sel_b  = 1'($urandom_range(0, 1));
      end
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
